// File: rtl/skid_buffer_p.sv
// Ready/valid register slice with registered m_valid/m_data/s_ready.
// MODE 0 keeps a main and a skid register (1 beat/cycle); MODE 1 keeps only main (1 beat/2 cycles).
module skid_buffer_p #(
  parameter int DATA_W = 8,
  parameter int MODE   = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic [1:0]        level
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  localparam bit HALF = (MODE == 1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [DATA_W-1:0] r_main;
  logic [DATA_W-1:0] r_skid;
  logic [DATA_W-1:0] w_main_nxt;
  logic [DATA_W-1:0] w_skid_nxt;
  logic              r_s_ready;
  logic              w_s_ready_nxt;
  logic              w_s_xfer;

  assign w_s_xfer = s_valid & r_s_ready;
  assign s_ready  = r_s_ready;
  assign m_valid  = (r_state != ST_EMPTY);
  assign m_data   = r_main;

  always_comb begin
    w_state_nxt = r_state;
    w_main_nxt  = r_main;
    w_skid_nxt  = r_skid;
    case (r_state)
      ST_EMPTY: begin
        if (w_s_xfer) begin
          w_main_nxt  = s_data;
          w_state_nxt = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (HALF) begin
          if (m_ready) w_state_nxt = ST_EMPTY;
        end else if (w_s_xfer && m_ready) begin
          w_main_nxt = s_data;
        end else if (w_s_xfer) begin
          w_skid_nxt  = s_data;
          w_state_nxt = ST_FULL;
        end else if (m_ready) begin
          w_state_nxt = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (m_ready) begin
          w_main_nxt  = r_skid;
          w_state_nxt = ST_BUSY;
        end
      end
      default: w_state_nxt = ST_EMPTY;
    endcase
    // Flush wins over every transition; a downstream beat this cycle has already left.
    if (flush) begin
      w_state_nxt = ST_EMPTY;
      w_main_nxt  = '0;
      w_skid_nxt  = '0;
    end
    w_s_ready_nxt = HALF ? (w_state_nxt == ST_EMPTY) : (w_state_nxt != ST_FULL);
  end

  always_comb begin
    level = 2'd0;
    case (r_state)
      ST_BUSY: level = 2'd1;
      ST_FULL: level = 2'd2;
      default: level = 2'd0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_EMPTY;
      r_main    <= '0;
      r_skid    <= '0;
      r_s_ready <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_main    <= w_main_nxt;
      r_skid    <= w_skid_nxt;
      r_s_ready <= w_s_ready_nxt;
    end
  end

endmodule

// File: tb/tb_skid_buffer_p.sv
// Bench for skid_buffer_p: a FULL-mode and a HALF-mode instance checked against queue models.
module tb_skid_buffer_p;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;

  logic        fl0 = 1'b0, sv0 = 1'b0, mr0 = 1'b0;
  logic [31:0] sd0 = '0;
  logic        s_ready0, m_valid0;
  logic [31:0] m_data0;
  logic [1:0]  level0;

  logic        fl1 = 1'b0, sv1 = 1'b0, mr1 = 1'b0;
  logic [31:0] sd1 = '0;
  logic        s_ready1, m_valid1;
  logic [31:0] m_data1;
  logic [1:0]  level1;

  int checks = 0;
  int errors = 0;

  // Reference: each instance is a FIFO of capacity 2 (FULL) or 1 (HALF) with
  // registered ready = "room left", zero while in reset.
  logic [31:0] q0[$];
  logic [31:0] q1[$];
  bit          rdy0 = 1'b0;
  bit          rdy1 = 1'b0;

  skid_buffer_p #(.DATA_W(32), .MODE(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .flush(fl0),
    .s_valid(sv0), .s_ready(s_ready0), .s_data(sd0),
    .m_valid(m_valid0), .m_ready(mr0), .m_data(m_data0), .level(level0)
  );

  skid_buffer_p #(.DATA_W(32), .MODE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .flush(fl1),
    .s_valid(sv1), .s_ready(s_ready1), .s_data(sd1),
    .m_valid(m_valid1), .m_ready(mr1), .m_data(m_data1), .level(level1)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic compare_all();
    chk("m_valid0", 32'(m_valid0), 32'(q0.size() > 0));
    chk("level0",   32'(level0),   32'(q0.size()));
    chk("s_ready0", 32'(s_ready0), 32'(rdy0));
    if (q0.size() > 0) chk("m_data0", m_data0, q0[0]);
    chk("m_valid1", 32'(m_valid1), 32'(q1.size() > 0));
    chk("level1",   32'(level1),   32'(q1.size()));
    chk("s_ready1", 32'(s_ready1), 32'(rdy1));
    if (q1.size() > 0) chk("m_data1", m_data1, q1[0]);
  endtask

  task automatic step();
    bit          pop0, push0, pop1, push1, stall0, stall1;
    logic [31:0] prev0, prev1, d0, d1;
    pop0   = (q0.size() > 0) && mr0;
    push0  = sv0 && rdy0;
    pop1   = (q1.size() > 0) && mr1;
    push1  = sv1 && rdy1;
    stall0 = m_valid0 && !mr0 && !fl0 && rst_n;
    stall1 = m_valid1 && !mr1 && !fl1 && rst_n;
    prev0  = m_data0;
    prev1  = m_data1;
    d0     = sd0;
    d1     = sd1;
    @(posedge clk);
    if (!rst_n) begin
      q0.delete(); q1.delete();
      rdy0 = 1'b0; rdy1 = 1'b0;
    end else begin
      if (pop0) void'(q0.pop_front());
      if (fl0) q0.delete(); else if (push0) q0.push_back(d0);
      if (pop1) void'(q1.pop_front());
      if (fl1) q1.delete(); else if (push1) q1.push_back(d1);
      rdy0 = (q0.size() < 2);
      rdy1 = (q1.size() < 1);
    end
    #1;
    compare_all();
    if (stall0) chk("stable0", m_data0, prev0);
    if (stall1) chk("stable1", m_data1, prev1);
  endtask

  initial begin
    int k, n, acc, cyc;

    // Asynchronous reset with no clock edge
    #2 rst_n = 1'b0;
    #1;
    chk("rst_m_valid0", 32'(m_valid0), 32'd0);
    chk("rst_m_data0",  m_data0,       32'd0);
    chk("rst_level0",   32'(level0),   32'd0);
    chk("rst_s_ready0", 32'(s_ready0), 32'd0);
    chk("rst_m_valid1", 32'(m_valid1), 32'd0);
    step();
    step();
    rst_n = 1'b1;
    step();
    chk("post_rst_rdy0", 32'(s_ready0), 32'd1);
    chk("post_rst_rdy1", 32'(s_ready1), 32'd1);

    // Full-rate stream
    for (int i = 0; i < 16; i++) begin
      sd0 = 32'(i); sv0 = 1'b1; mr0 = 1'b1;
      step();
      chk("stream_data", m_data0, 32'(i));
      chk("stream_vld",  32'(m_valid0), 32'd1);
      chk("stream_rdy",  32'(s_ready0), 32'd1);
    end
    sv0 = 1'b0;
    step();
    chk("stream_end", 32'(m_valid0), 32'd0);

    // Backpressure into the skid register
    mr0 = 1'b0; sv0 = 1'b1; sd0 = 32'hA1;
    step();
    sd0 = 32'hA2;
    step();
    chk("bp_level", 32'(level0), 32'd2);
    chk("bp_rdy",   32'(s_ready0), 32'd0);
    chk("bp_head",  m_data0, 32'hA1);
    sd0 = 32'hA3;
    step();
    chk("bp_hold", m_data0, 32'hA1);
    chk("bp_hold_level", 32'(level0), 32'd2);
    mr0 = 1'b1;
    step();
    chk("bp_out2", m_data0, 32'hA2);
    chk("bp_vld2", 32'(m_valid0), 32'd1);
    step();
    chk("bp_out3", m_data0, 32'hA3);
    chk("bp_vld3", 32'(m_valid0), 32'd1);
    sv0 = 1'b0;
    step();
    chk("bp_drained", 32'(m_valid0), 32'd0);

    // Half-rate slice
    k = 0; n = 0; mr1 = 1'b1;
    for (int c = 0; c < 16; c++) begin
      sd1 = 32'h10 + 32'(k);
      sv1 = (k < 8);
      chk("half_rdy", 32'(s_ready1), 32'(c % 2 == 0));
      if (m_valid1 && mr1) begin
        chk("half_data", m_data1, 32'h10 + 32'(n));
        n++;
      end
      if (sv1 && rdy1) k++;
      step();
    end
    chk("half_sent", 32'(k), 32'd8);
    chk("half_delivered", 32'(n), 32'd8);
    sv1 = 1'b0;
    step();

    // Flush from FULL while upstream offers 0x77
    mr0 = 1'b0; sv0 = 1'b1; sd0 = 32'h55;
    step();
    sd0 = 32'h66;
    step();
    chk("fl_full", 32'(level0), 32'd2);
    sd0 = 32'h77; fl0 = 1'b1;
    step();
    chk("fl_vld",   32'(m_valid0), 32'd0);
    chk("fl_level", 32'(level0),   32'd0);
    chk("fl_data",  m_data0,       32'd0);
    fl0 = 1'b0; sv0 = 1'b0; mr0 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("fl_gone", 32'(m_valid0), 32'd0);
    end

    // Flush from BUSY discards a beat handshaken in the same cycle
    mr0 = 1'b0; sv0 = 1'b1; sd0 = 32'h88;
    step();
    sd0 = 32'h99; fl0 = 1'b1;
    step();
    chk("fl_busy_level", 32'(level0), 32'd0);
    chk("fl_busy_vld",   32'(m_valid0), 32'd0);
    fl0 = 1'b0; sv0 = 1'b0;
    step();

    // Reset mid-operation, asserted between edges
    mr0 = 1'b0; sv0 = 1'b1; sd0 = 32'hC1;
    mr1 = 1'b0; sv1 = 1'b1; sd1 = 32'hD1;
    step();
    sd0 = 32'hC2;
    step();
    sv0 = 1'b0; sv1 = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_vld0",  32'(m_valid0), 32'd0);
    chk("mid_rst_data0", m_data0,       32'd0);
    chk("mid_rst_lvl0",  32'(level0),   32'd0);
    chk("mid_rst_rdy0",  32'(s_ready0), 32'd0);
    chk("mid_rst_vld1",  32'(m_valid1), 32'd0);
    chk("mid_rst_data1", m_data1,       32'd0);
    q0.delete(); q1.delete();
    rdy0 = 1'b0; rdy1 = 1'b0;
    rst_n = 1'b1;
    step();

    // Random traffic on both slices
    acc = 0; cyc = 0;
    while (acc < 10000 && cyc < 60000) begin
      sv0 = 1'($urandom_range(0, 1)); mr0 = 1'($urandom_range(0, 1)); sd0 = $urandom;
      sv1 = 1'($urandom_range(0, 1)); mr1 = 1'($urandom_range(0, 1)); sd1 = $urandom;
      if (sv0 && rdy0) acc++;
      step();
      cyc++;
    end
    chk("rand_beats_done", 32'(acc >= 10000), 32'd1);
    sv0 = 1'b0; sv1 = 1'b0; mr0 = 1'b1; mr1 = 1'b1;
    for (int i = 0; i < 3; i++) step();
    chk("rand_drain0", 32'(level0), 32'd0);
    chk("rand_drain1", 32'(level1), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
